// File: rtl/waterfall_scroller.sv
// waterfall_scroller: clears the frame buffer, maps video x/y through a circular
// row offset, and scrolls one bin line per blanking. Build macro: WATERFALL_REVERSE_EN.
module waterfall_scroller #(
  parameter int H_VISIBLE  = 320,
  parameter int V_VISIBLE  = 240,
  parameter int X_W        = 9,
  parameter int Y_W        = 8,
  parameter int FB_ADDR_W  = 17,
  parameter int PIX_W      = 8,
  parameter int BINS       = 320,
  parameter int BIN_ADDR_W = 9,
  parameter int DIV_W      = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [X_W-1:0]        x,
  input  logic [Y_W-1:0]        y,
  input  logic                  visible,
  input  logic                  lower_blank,
  input  logic [DIV_W-1:0]      scroll_div,
  input  logic                  freeze,
  output logic [FB_ADDR_W-1:0]  fb_addr,
  output logic [PIX_W-1:0]      fb_wdata,
  output logic                  fb_we,
  input  logic [PIX_W-1:0]      fb_rdata,
  output logic [PIX_W-1:0]      pix_out,
  output logic [BIN_ADDR_W-1:0] bin_addr,
  output logic                  bin_re,
  input  logic [PIX_W-1:0]      bin_rdata,
  output logic                  clear_busy,
  output logic                  line_done,
  output logic [Y_W-1:0]        y_offset
);

  localparam int N_PIX = H_VISIBLE * V_VISIBLE;
  localparam int K_W   = $clog2(H_VISIBLE + 1);

  localparam logic [FB_ADDR_W-1:0] L_CLR_LAST = FB_ADDR_W'(N_PIX - 1);
  localparam logic [FB_ADDR_W-1:0] L_H        = FB_ADDR_W'(H_VISIBLE);
  localparam logic [Y_W:0]         L_VS       = (Y_W + 1)'(V_VISIBLE);
  localparam logic [Y_W-1:0]       L_VLAST    = Y_W'(V_VISIBLE - 1);
  localparam logic [K_W-1:0]       L_KLAST    = K_W'(H_VISIBLE);
  localparam logic [K_W-1:0]       L_BINS     = K_W'(BINS);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_VIDEO,
    S_COPY,
    S_WAIT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [FB_ADDR_W-1:0]  r_clr;
  logic [K_W-1:0]        r_k;
  logic [FB_ADDR_W-1:0]  r_rowbase;
  logic [Y_W-1:0]        r_row;
  logic [Y_W-1:0]        r_yoff;
  logic [DIV_W-1:0]      r_frm;
  logic                  r_lb_d;
  logic                  r_vis1;
  logic                  r_vis2;
  logic                  r_wbin;
  logic [FB_ADDR_W-1:0]  r_fb_addr;
  logic                  r_fb_we;
  logic [BIN_ADDR_W-1:0] r_bin_addr;
  logic                  r_bin_re;
  logic                  r_line_done;

  logic                  w_rise;
  logic                  w_clr_last;
  logic                  w_k_last;
  logic                  w_go_copy;
  logic [Y_W:0]          w_ysum;
  logic [Y_W:0]          w_ymod;
  logic [FB_ADDR_W-1:0]  w_map;
  logic [Y_W-1:0]        w_tgt;
  logic [Y_W-1:0]        w_ynext;
  logic [FB_ADDR_W-1:0]  w_rowbase;
  logic [K_W-1:0]        w_kp1;

  assign w_rise     = lower_blank & ~r_lb_d;
  assign w_clr_last = (r_clr == L_CLR_LAST);
  assign w_k_last   = (r_k == L_KLAST);
  assign w_go_copy  = w_rise & ~freeze & (r_frm == scroll_div);
  assign w_ysum     = {1'b0, y} + {1'b0, r_yoff};
  assign w_ymod     = (w_ysum >= L_VS) ? (w_ysum - L_VS) : w_ysum;
  assign w_map      = FB_ADDR_W'(w_ymod) * L_H + FB_ADDR_W'(x);
  assign w_rowbase  = FB_ADDR_W'(w_tgt) * L_H;
  assign w_kp1      = r_k + K_W'(1);

`ifdef WATERFALL_REVERSE_EN
  // newest line goes one row above the current top, which becomes the new top
  assign w_tgt   = (r_yoff == '0) ? L_VLAST : (r_yoff - Y_W'(1));
  assign w_ynext = r_row;
`else
  // newest line overwrites the oldest row; top moves down one row
  assign w_tgt   = r_yoff;
  assign w_ynext = (r_row == L_VLAST) ? '0 : (r_row + Y_W'(1));
`endif

  assign fb_addr    = r_fb_addr;
  assign fb_we      = r_fb_we;
  assign fb_wdata   = r_wbin ? bin_rdata : '0;
  assign bin_addr   = r_bin_addr;
  assign bin_re     = r_bin_re;
  assign line_done  = r_line_done;
  assign y_offset   = r_yoff;
  assign clear_busy = (r_state == S_CLEAR);
  assign pix_out    = (r_vis2 && r_state == S_VIDEO) ? fb_rdata : '0;

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_CLEAR;
    else         r_state <= w_next;
  end

  // next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_CLEAR: if (w_clr_last) w_next = S_VIDEO;
      S_VIDEO: if (w_rise) w_next = w_go_copy ? S_COPY : S_WAIT;
      S_COPY:  if (w_k_last) w_next = S_WAIT;
      S_WAIT:  if (!lower_blank) w_next = S_VIDEO;
      default: w_next = S_CLEAR;
    endcase
  end

  // clear sweep, address mapping, line copy and scroll bookkeeping
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_clr       <= '0;
      r_k         <= '0;
      r_rowbase   <= '0;
      r_row       <= '0;
      r_yoff      <= '0;
      r_frm       <= '0;
      r_lb_d      <= 1'b0;
      r_vis1      <= 1'b0;
      r_vis2      <= 1'b0;
      r_wbin      <= 1'b0;
      r_fb_addr   <= '0;
      r_fb_we     <= 1'b0;
      r_bin_addr  <= '0;
      r_bin_re    <= 1'b0;
      r_line_done <= 1'b0;
    end else begin
      r_lb_d      <= lower_blank;
      r_vis1      <= visible;
      r_vis2      <= r_vis1;
      r_line_done <= 1'b0;
      r_fb_we     <= 1'b0;
      r_wbin      <= 1'b0;
      r_bin_re    <= 1'b0;
      r_bin_addr  <= '0;
      unique case (r_state)
        S_CLEAR: begin
          r_fb_addr <= r_clr;
          r_fb_we   <= 1'b1;
          r_clr     <= r_clr + FB_ADDR_W'(1);
        end
        S_VIDEO: begin
          r_fb_addr <= w_map;
          if (w_rise && !freeze) begin
            if (w_go_copy) begin
              r_frm     <= '0;
              r_row     <= w_tgt;
              r_rowbase <= w_rowbase;
              r_k       <= '0;
              r_bin_re  <= 1'b1;
            end else begin
              r_frm <= r_frm + DIV_W'(1);
            end
          end
        end
        S_COPY: begin
          if (w_k_last) begin
            r_yoff      <= w_ynext;
            r_line_done <= 1'b1;
          end else begin
            r_fb_addr <= r_rowbase + FB_ADDR_W'(r_k);
            r_fb_we   <= 1'b1;
            r_wbin    <= (r_k < L_BINS);
            r_k       <= w_kp1;
            if (w_kp1 < L_BINS) begin
              r_bin_addr <= BIN_ADDR_W'(w_kp1);
              r_bin_re   <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          r_fb_addr <= w_map;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_waterfall_scroller.sv
// tb_waterfall_scroller: scoreboard bench for waterfall_scroller on a
// reduced 16x8 frame with 12 bins, so the extra columns are zero-filled.
`timescale 1ns/1ps
module tb_waterfall_scroller;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int NB = 12;
  localparam int XW = 5;
  localparam int YW = 4;
  localparam int AW = 7;
  localparam int PW = 8;
  localparam int BW = 4;
  localparam int DW = 4;
  localparam int N  = H * V;

  logic          clk = 1'b0;
  logic          resetn;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          visible;
  logic          lower_blank;
  logic [DW-1:0] scroll_div;
  logic          freeze;
  logic [AW-1:0] fb_addr;
  logic [PW-1:0] fb_wdata;
  logic          fb_we;
  logic [PW-1:0] fb_rdata;
  logic [PW-1:0] pix_out;
  logic [BW-1:0] bin_addr;
  logic          bin_re;
  logic [PW-1:0] bin_rdata;
  logic          clear_busy;
  logic          line_done;
  logic [YW-1:0] y_offset;

  int n_chk;
  int n_fail;
  int yoff_m;
  int frm_m;

  logic [PW-1:0]    mem [N];
  logic [PW-1:0]    ref_mem [N];
  logic             fill_req;
  logic             fill_sel;
  logic [AW+PW-1:0] obs_q [$];
  logic [AW+PW-1:0] exp_q [$];

  always #5 clk = ~clk;

  waterfall_scroller #(
    .H_VISIBLE(H), .V_VISIBLE(V), .X_W(XW), .Y_W(YW),
    .FB_ADDR_W(AW), .PIX_W(PW), .BINS(NB), .BIN_ADDR_W(BW), .DIV_W(DW)
  ) dut (
    .clk(clk), .resetn(resetn), .x(x), .y(y), .visible(visible),
    .lower_blank(lower_blank), .scroll_div(scroll_div), .freeze(freeze),
    .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_we(fb_we),
    .fb_rdata(fb_rdata), .pix_out(pix_out), .bin_addr(bin_addr),
    .bin_re(bin_re), .bin_rdata(bin_rdata), .clear_busy(clear_busy),
    .line_done(line_done), .y_offset(y_offset)
  );

  function automatic logic [PW-1:0] bin_val(input int k);
    return PW'((k * 29 + 7) & 255);
  endfunction

  function automatic logic [PW-1:0] fill_val(input int a, input logic sel);
    return sel ? PW'((a * 37 + 11) & 255) : 8'hFF;
  endfunction

  // frame-buffer RAM: synchronous read-before-write, bench-side bulk fill
  always @(posedge clk) begin
    fb_rdata <= mem[fb_addr];
    if (fill_req) begin
      for (int a = 0; a < N; a++) mem[a] = fill_val(a, fill_sel);
    end else if (fb_we === 1'b1) begin
      mem[fb_addr] = fb_wdata;
    end
  end

  // bin BRAM: synchronous read
  always @(posedge clk) begin
    if (bin_re === 1'b1) bin_rdata <= bin_val(int'(bin_addr));
  end

  // write monitor feeding the observed side of the scoreboard
  always @(negedge clk) begin
    if (resetn === 1'b1 && fb_we === 1'b1) obs_q.push_back({fb_addr, fb_wdata});
  end

  task automatic do_fill(input logic sel);
    fill_sel = sel;
    fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
    for (int a = 0; a < N; a++) ref_mem[a] = fill_val(a, sel);
  endtask

  // one blanking interval; queues the expected copy when the model says one is due
  task automatic run_blank(input int hold, output int pulses, output int zviol,
                           output int ld_at);
    int r;
    bit copied;
    logic [PW-1:0] d;
    copied = 0;
    r = 0;
    if (!freeze) begin
      if (frm_m == int'(scroll_div)) begin
        frm_m = 0;
        copied = 1;
      end else begin
        frm_m = (frm_m + 1) % (1 << DW);
      end
    end
    if (copied) begin
`ifdef WATERFALL_REVERSE_EN
      r = (yoff_m == 0) ? V - 1 : yoff_m - 1;
      yoff_m = r;
`else
      r = yoff_m;
      yoff_m = (yoff_m + 1) % V;
`endif
      for (int k = 0; k < H; k++) begin
        d = (k < NB) ? bin_val(k) : 8'h00;
        exp_q.push_back({AW'(r * H + k), d});
        ref_mem[r * H + k] = d;
      end
    end
    pulses = 0;
    zviol = 0;
    ld_at = -1;
    lower_blank = 1'b1;
    for (int i = 1; i <= hold + H + 8; i++) begin
      @(negedge clk);
      if (line_done === 1'b1) begin
        pulses++;
        ld_at = i;
      end
      if (i <= hold && pix_out !== '0) zviol++;
      if (i == hold) lower_blank = 1'b0;
    end
  endtask

  task automatic test_reset();
    int fall_at;
    int zbad;
    logic [AW+PW-1:0] o, e;
    resetn = 1'b0;
    visible = 1'b1;
    x = '0;
    y = '0;
    do_fill(1'b0);
    @(negedge clk);
    n_chk++;
    if (clear_busy !== 1'b1 || fb_we !== 1'b0 || fb_addr !== '0 ||
        y_offset !== '0 || line_done !== 1'b0 || bin_re !== 1'b0 ||
        bin_addr !== '0 || pix_out !== '0 || fb_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_values: busy=%b we=%b addr=%0d yoff=%0d ld=%b re=%b pix=%0h, required busy=1 and all others 0",
               clear_busy, fb_we, fb_addr, y_offset, line_done, bin_re, pix_out);
    end
    obs_q.delete();
    exp_q.delete();
    for (int a = 0; a < N; a++) begin
      exp_q.push_back({AW'(a), 8'h00});
      ref_mem[a] = 8'h00;
    end
    resetn = 1'b1;
    fall_at = -1;
    zbad = 0;
    for (int i = 1; i <= N + 8; i++) begin
      @(negedge clk);
      if (clear_busy === 1'b1 && pix_out !== '0) zbad++;
      if (fall_at < 0 && clear_busy !== 1'b1) fall_at = i;
    end
    n_chk++;
    if (fall_at != N) begin
      n_fail++;
      $display("FAIL clear_length: busy fell at cycle %0d, required %0d", fall_at, N);
    end
    n_chk++;
    if (zbad != 0) begin
      n_fail++;
      $display("FAIL clear_pix_zero: %0d nonzero pixels, required 0", zbad);
    end
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL clear_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL clear_write: got addr %0d data %0h, required addr %0d data %0h",
                 o[AW+PW-1:PW], o[PW-1:0], e[AW+PW-1:PW], e[PW-1:0]);
      end
    end
    obs_q.delete();
    exp_q.delete();
    yoff_m = 0;
    frm_m = 0;
  endtask

  task automatic test_pixel_map(input int n, input bit preload);
    logic [PW-1:0] pq [$];
    logic [PW-1:0] e;
    int xs, ys;
    bit vs;
    lower_blank = 1'b0;
    if (preload) do_fill(1'b1);
    for (int s = 0; s < n + 2; s++) begin
      if (s >= 2) begin
        e = pq.pop_front();
        n_chk++;
        if (pix_out !== e) begin
          n_fail++;
          $display("FAIL pixel_map: step %0d got %0h, required %0h", s - 2, pix_out, e);
        end
      end
      if (s < n) begin
        xs = $urandom_range(H - 1);
        ys = $urandom_range(V - 1);
        vs = ($urandom_range(3) != 0);
        x = XW'(xs);
        y = YW'(ys);
        visible = vs;
        pq.push_back(vs ? ref_mem[((ys + yoff_m) % V) * H + xs] : 8'h00);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single_scroll();
    int p, z, ld;
    logic [AW+PW-1:0] o, e;
    logic [YW-1:0] yexp;
    freeze = 1'b0;
    scroll_div = '0;
    visible = 1'b1;
    x = 5'd3;
    y = 4'd2;
    run_blank(H + 4, p, z, ld);
    n_chk++;
    if (p != 1) begin
      n_fail++;
      $display("FAIL scroll_pulses: got %0d line_done pulses, required 1", p);
    end
    n_chk++;
    if (ld != H + 2) begin
      n_fail++;
      $display("FAIL scroll_latency: line_done at cycle %0d, required %0d", ld, H + 2);
    end
    n_chk++;
    if (z != 0) begin
      n_fail++;
      $display("FAIL scroll_pix_zero: %0d nonzero pixels in blank, required 0", z);
    end
`ifdef WATERFALL_REVERSE_EN
    yexp = YW'(V - 1);
`else
    yexp = YW'(1);
`endif
    n_chk++;
    if (y_offset !== yexp) begin
      n_fail++;
      $display("FAIL scroll_yoffset: got %0d, required %0d", y_offset, yexp);
    end
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL scroll_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL scroll_write: got addr %0d data %0h, required addr %0d data %0h",
                 o[AW+PW-1:PW], o[PW-1:0], e[AW+PW-1:PW], e[PW-1:0]);
      end
    end
    obs_q.delete();
    exp_q.delete();
`ifdef WATERFALL_REVERSE_EN
    y = '0;
`else
    y = YW'(V - 1);
`endif
    x = 5'd5;
    visible = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (pix_out !== bin_val(5)) begin
      n_fail++;
      $display("FAIL scroll_newline_pix: got %0h, required %0h", pix_out, bin_val(5));
    end
  endtask

  task automatic test_divider_freeze();
    int p, z, ld;
    logic [AW+PW-1:0] o, e;
    freeze = 1'b0;
    scroll_div = 4'd3;
    for (int f = 0; f < 8; f++) begin
      run_blank(H + 4, p, z, ld);
      n_chk++;
      if (p != ((f % 4 == 3) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL div_pulses: frame %0d got %0d pulses, required %0d", f, p, (f % 4 == 3) ? 1 : 0);
      end
    end
    freeze = 1'b1;
    for (int f = 0; f < 4; f++) begin
      run_blank(H + 4, p, z, ld);
      n_chk++;
      if (p != 0) begin
        n_fail++;
        $display("FAIL freeze_pulses: frame %0d got %0d pulses, required 0", f, p);
      end
    end
    freeze = 1'b0;
    for (int f = 0; f < 4; f++) begin
      run_blank(H + 4, p, z, ld);
      n_chk++;
      if (p != ((f == 3) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL freeze_held_count: frame %0d got %0d pulses, required %0d", f, p, (f == 3) ? 1 : 0);
      end
    end
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL div_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL div_write: got addr %0d data %0h, required addr %0d data %0h",
                 o[AW+PW-1:PW], o[PW-1:0], e[AW+PW-1:PW], e[PW-1:0]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_wrap();
    int p, z, ld;
    logic [AW+PW-1:0] o, e;
    logic [YW-1:0] y0;
    scroll_div = '0;
    freeze = 1'b0;
    y0 = y_offset;
    for (int f = 0; f < V + 1; f++) begin
      run_blank(H + 4, p, z, ld);
      n_chk++;
      if (y_offset !== YW'(yoff_m) || int'(y_offset) >= V) begin
        n_fail++;
        $display("FAIL wrap_yoffset: scroll %0d got %0d, required %0d", f, y_offset, yoff_m);
      end
      if (f == V - 1) begin
        n_chk++;
        if (y_offset !== y0) begin
          n_fail++;
          $display("FAIL wrap_full_cycle: got %0d, required %0d", y_offset, y0);
        end
      end
    end
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL wrap_write: got addr %0d data %0h, required addr %0d data %0h",
                 o[AW+PW-1:PW], o[PW-1:0], e[AW+PW-1:PW], e[PW-1:0]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_midcopy_events();
    int p, z, ld, fall_at;
    logic [AW+PW-1:0] o, e;
    scroll_div = '0;
    freeze = 1'b0;
    visible = 1'b1;
    run_blank(6, p, z, ld);
    n_chk++;
    if (p != 1 || ld != H + 2) begin
      n_fail++;
      $display("FAIL midcopy_drop_done: got %0d pulses at cycle %0d, required 1 at %0d", p, ld, H + 2);
    end
    n_chk++;
    if (z != 0) begin
      n_fail++;
      $display("FAIL midcopy_pix_zero: %0d nonzero pixels, required 0", z);
    end
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL midcopy_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL midcopy_write: got addr %0d data %0h, required addr %0d data %0h",
                 o[AW+PW-1:PW], o[PW-1:0], e[AW+PW-1:PW], e[PW-1:0]);
      end
    end
    obs_q.delete();
    exp_q.delete();
    lower_blank = 1'b1;
    repeat (6) @(negedge clk);
    n_chk++;
    if (fb_we !== 1'b1) begin
      n_fail++;
      $display("FAIL midcopy_active: fb_we=%b, required 1", fb_we);
    end
    resetn = 1'b0;
    #1;
    n_chk++;
    if (clear_busy !== 1'b1 || fb_addr !== '0 || y_offset !== '0 ||
        fb_we !== 1'b0 || bin_re !== 1'b0 || line_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midcopy_reset: busy=%b addr=%0d yoff=%0d we=%b re=%b ld=%b, required 1 0 0 0 0 0",
               clear_busy, fb_addr, y_offset, fb_we, bin_re, line_done);
    end
    lower_blank = 1'b0;
    @(negedge clk);
    obs_q.delete();
    exp_q.delete();
    for (int a = 0; a < N; a++) begin
      exp_q.push_back({AW'(a), 8'h00});
      ref_mem[a] = 8'h00;
    end
    resetn = 1'b1;
    fall_at = -1;
    for (int i = 1; i <= N + 8; i++) begin
      @(negedge clk);
      if (fall_at < 0 && clear_busy !== 1'b1) fall_at = i;
    end
    yoff_m = 0;
    frm_m = 0;
    n_chk++;
    if (fall_at != N) begin
      n_fail++;
      $display("FAIL reclear_length: busy fell at cycle %0d, required %0d", fall_at, N);
    end
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL reclear_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reclear_write: got addr %0d data %0h, required addr %0d data %0h",
                 o[AW+PW-1:PW], o[PW-1:0], e[AW+PW-1:PW], e[PW-1:0]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    yoff_m = 0;
    frm_m = 0;
    resetn = 1'b0;
    x = '0;
    y = '0;
    visible = 1'b0;
    lower_blank = 1'b0;
    scroll_div = '0;
    freeze = 1'b0;
    fill_req = 1'b0;
    fill_sel = 1'b0;
    test_reset();
    test_pixel_map(24, 1'b1);
    test_single_scroll();
    test_divider_freeze();
    test_wrap();
    test_pixel_map(16, 1'b0);
    test_midcopy_events();
    test_pixel_map(12, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/waterfall_scroller.md
# waterfall_scroller

Parametrised scrolling frame-buffer controller for the waterfall display. It sits between the video timing generator, the single-port frame-buffer RAM and the frequency-bin BRAM.
- Clears the frame buffer after reset.
- Maps video `x`/`y` to frame-buffer addresses through a circular row offset.
- During lower blanking, every `scroll_div+1` frames, copies one line of bins into the oldest row, which scrolls the image by one line.

## Interface
Parameters:
- `H_VISIBLE`, 320, visible columns (frame-buffer row length)
- `V_VISIBLE`, 240, visible rows
- `X_W`, 9, width of `x`
- `Y_W`, 8, width of `y` and `y_offset`
- `FB_ADDR_W`, 17, frame-buffer address width; must satisfy 2^FB_ADDR_W ≥ H_VISIBLE*V_VISIBLE
- `PIX_W`, 8, pixel/bin magnitude width
- `BINS`, 320, bins copied per line; must be ≤ H_VISIBLE
- `BIN_ADDR_W`, 9, bin BRAM address width
- `DIV_W`, 4, width of `scroll_div`

Ports:
- `clk` in 1: pixel clock
- `resetn` in 1: asynchronous active-low reset
- `x` in X_W: current video column
- `y` in Y_W: current video row
- `visible` in 1: active video
- `lower_blank` in 1: high during vertical blanking after the last row
- `scroll_div` in DIV_W: frames per scroll minus 1
- `freeze` in 1: inhibits scrolling
- `fb_addr` out FB_ADDR_W: frame-buffer address
- `fb_wdata` out PIX_W: frame-buffer write data
- `fb_we` out 1: frame-buffer write enable
- `fb_rdata` in PIX_W: frame-buffer read data, 1-cycle synchronous read
- `pix_out` out PIX_W: pixel to the gradient ROM
- `bin_addr` out BIN_ADDR_W: bin BRAM read address
- `bin_re` out 1: bin BRAM read enable
- `bin_rdata` in PIX_W: bin data, 1-cycle synchronous read
- `clear_busy` out 1: high while the frame buffer is being cleared
- `line_done` out 1: single-cycle pulse after each completed line copy
- `y_offset` out Y_W: current top-of-screen row

## Operation
- Reset values:
  - `fb_addr`, `fb_wdata`, `fb_we`, `pix_out`, `bin_addr`, `bin_re`, `line_done`, `y_offset`, frame counter: all 0.
  - `clear_busy` = 1. State = CLEAR.
- CLEAR:
  - Write 0 to addresses 0 … H_VISIBLE*V_VISIBLE−1, one per cycle, with `fb_we`=1.
  - After the last address: `fb_we`=0, `clear_busy`=0, go to VIDEO.
- VIDEO, row mapping:
  - `ymod` = `y` + `y_offset`, minus V_VISIBLE if the sum ≥ V_VISIBLE. Compute at width Y_W+1; no overflow is allowed.
  - `fb_addr` = `ymod`*H_VISIBLE + `x`, registered. The multiply is by a constant.
- VIDEO, blank entry: on the rising edge of `lower_blank`:
  - If `freeze`: go to WAIT.
  - Else if counter == `scroll_div`: clear the counter, go to COPY.
  - Else: increment the counter, go to WAIT.
  - `scroll_div` is sampled only at this edge.
- COPY:
  - Target row `r` = `y_offset`.
  - Issue `bin_addr` k = 0 … BINS−1 with `bin_re`=1.
  - One cycle later, write `bin_rdata` to `r`*H_VISIBLE + k.
  - Columns BINS … H_VISIBLE−1 of row `r` are written with 0.
  - After the final write: `y_offset` ← (`y_offset`+1) wraps to 0 after V_VISIBLE−1, pulse `line_done`, go to WAIT.
- COPY completes even if `lower_blank` falls mid-copy. `pix_out` is forced to 0 while in COPY.
- WAIT: go to VIDEO when `lower_blank`=0.
- Pixel path: `pix_out` = `fb_rdata` when `visible` delayed by 2 cycles is 1 and the state is VIDEO; otherwise 0.

## Timing
- Pixel latency: `x`/`y` at cycle t → `fb_addr` at t+1 → `fb_rdata` and `pix_out` at t+2.
- COPY length: H_VISIBLE+1 cycles from the first `bin_addr` to the last write. `line_done` is asserted in the following cycle.
- CLEAR length: H_VISIBLE*V_VISIBLE cycles.
- `resetn` asserted at any time, including mid-COPY or mid-CLEAR: all outputs go to their reset values immediately. After release, CLEAR restarts at address 0.
- If `lower_blank` is already high when CLEAR ends, it is not treated as an edge. The first scroll decision happens in the next blanking interval.

## Configuration
- `WATERFALL_REVERSE_EN` defined: scroll direction is inverted.
  - COPY writes row `r` = (`y_offset` − 1) mod V_VISIBLE, then `y_offset` ← `r`.
  - The newest line appears at the top and the image moves down.
- `WATERFALL_REVERSE_EN` undefined: the newest line is written at the old `y_offset` and appears at the bottom; the image moves up.

## Test plan
- Reset/clear: preload the RAM with 0xFF, release `resetn` → exactly 76800 writes of 0; `clear_busy` falls at cycle 76800; `pix_out` stays 0 throughout.
- Single scroll: `scroll_div`=0, bins k = k&0xFF, one blank → row 0 holds 0…255,0…63 (320 columns); `y_offset`=1; one `line_done` pulse; `y`=239 at `x`=5 gives `pix_out`=5.
- Divider/freeze: `scroll_div`=3 → one copy per 4 blanks over 16 frames (4 `line_done` pulses); assert `freeze` → 0 pulses and counter held.
- Wrap: 241 scrolls → `y_offset` goes 239→0, never 240; the 241st line is written at row 0.
- Mid-copy events: drop `lower_blank` at k=100 → copy completes 320 writes with `pix_out`=0 meanwhile; assert `resetn` at k=100 → state CLEAR, `fb_addr`=0, `y_offset`=0.
- `WATERFALL_REVERSE_EN` build: first scroll writes row 239, `y_offset`=239; with `y`=0, `pix_out` shows the new line.
